snake_body_streamer: RTL and testbench

SNAKE_BODY_STREAMER -- requirements
Module: snake_body_streamer

---
 rtl/snake_body_streamer_pkg.sv | 40 ++++
 rtl/snake_body_streamer_next_head.sv | 43 ++++
 rtl/snake_body_streamer.sv | 186 ++++++++++++++++++
 tb/tb_snake_body_streamer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_body_streamer_pkg.sv
// Shared snake constants, encodings and coordinate type.
// Also used by the graphic block for playfield geometry.
package snake_body_streamer_pkg;

   localparam int X_BLOCKS         = 124;
   localparam int Y_BLOCKS         = 81;
   localparam int SNAKE_LENGTH_MAX = 16;
   localparam int SNAKE_LENGTH_BIT = 4;
   localparam int COORD_W          = 7;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_UPDATE = 2'b01,
      ST_CHECK  = 2'b10,
      ST_OVER   = 2'b11
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } coord_t;

   localparam coord_t OFF_COORD  = coord_t'({7'd127, 7'd127});
   localparam coord_t INIT_HEAD  = coord_t'({7'd62, 7'd40});
   localparam coord_t INIT_BODY0 = coord_t'({7'd61, 7'd40});
   localparam coord_t INIT_BODY1 = coord_t'({7'd60, 7'd40});

   // Up/down and left/right differ only in the top bit.
   function automatic logic [1:0] opposite(input logic [1:0] d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/snake_body_streamer_next_head.sv
// Next head position, heading selection and wall detection.
// Purely combinational; head is held when a wall is hit.
module snake_next_head #(
   parameter int X_BLOCKS = snake_body_streamer_pkg::X_BLOCKS,
   parameter int Y_BLOCKS = snake_body_streamer_pkg::Y_BLOCKS
) (
   input  logic [6:0] head_x,
   input  logic [6:0] head_y,
   input  logic [1:0] heading,
   input  logic [1:0] direction,
   output logic [6:0] next_x,
   output logic [6:0] next_y,
   output logic [1:0] new_heading,
   output logic       wall_hit
);
   import snake_body_streamer_pkg::*;

   localparam logic [6:0] X_LAST = 7'(X_BLOCKS - 1);
   localparam logic [6:0] Y_LAST = 7'(Y_BLOCKS - 1);

   // Reject reversal, then step one block or flag the wall
   always_comb begin
      new_heading = (direction == opposite(heading)) ? heading : direction;
      next_x      = head_x;
      next_y      = head_y;
      wall_hit    = 1'b0;
      unique case (new_heading)
         DIR_UP:
            if (head_y == 7'd0) wall_hit = 1'b1;
            else next_y = head_y - 7'd1;
         DIR_RIGHT:
            if (head_x >= X_LAST) wall_hit = 1'b1;
            else next_x = head_x + 7'd1;
         DIR_DOWN:
            if (head_y >= Y_LAST) wall_hit = 1'b1;
            else next_y = head_y + 7'd1;
         default:
            if (head_x == 7'd0) wall_hit = 1'b1;
            else next_x = head_x - 7'd1;
      endcase
   end

endmodule

// File: rtl/snake_body_streamer.sv
// Snake head/body state with a never-stalling body stream.
// Steps are applied in UPDATE, then self-collision is scanned in CHECK.
module snake_body_streamer #(
   parameter int SNAKE_LENGTH_BIT = snake_body_streamer_pkg::SNAKE_LENGTH_BIT,
   parameter int SNAKE_LENGTH_MAX = snake_body_streamer_pkg::SNAKE_LENGTH_MAX,
   parameter int X_BLOCKS         = snake_body_streamer_pkg::X_BLOCKS,
   parameter int Y_BLOCKS         = snake_body_streamer_pkg::Y_BLOCKS
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic                        move_tick,
   input  logic [1:0]                  direction,
   input  logic                        grow,
   input  logic                        restart,
   output logic [6:0]                  snake_head_x,
   output logic [6:0]                  snake_head_y,
   output logic [SNAKE_LENGTH_BIT-1:0] body_count,
   output logic [6:0]                  snake_body_x,
   output logic [6:0]                  snake_body_y,
   output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
   output logic                        game_over,
   output logic                        busy
);
   import snake_body_streamer_pkg::*;

   // Length needs one extra bit so a full array (MAX) is representable.
   localparam int LW = SNAKE_LENGTH_BIT + 1;
   localparam logic [SNAKE_LENGTH_BIT-1:0] LAST_IDX =
      SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
   localparam logic [LW-1:0] LEN_MAX  = LW'(SNAKE_LENGTH_MAX);
   localparam logic [LW-1:0] LEN_INIT = LW'(2);

   typedef coord_t [SNAKE_LENGTH_MAX-1:0] body_t;

   function automatic body_t body_init();
      body_t b;
      for (int i = 0; i < SNAKE_LENGTH_MAX; i++) b[i] = OFF_COORD;
      b[0] = INIT_BODY0;
      b[1] = INIT_BODY1;
      return b;
   endfunction

   state_t                      state;
   state_t                      state_n;
   coord_t                      head;
   coord_t                      next_head;
   coord_t                      snake_body;
   dir_t                        heading;
   dir_t                        step_dir;
   dir_t                        pend_dir;
   logic [1:0]                  new_heading;
   logic                        step_grow;
   logic                        pend_grow;
   logic                        pending;
   logic                        wall_hit;
   logic                        grow_ok;
   logic                        scan_done;
   logic                        scan_hit;
   logic [LW-1:0]               len;
   logic [LW-1:0]               scan_idx;
   logic [SNAKE_LENGTH_BIT-1:0] rd_idx;
   body_t                       body;

   snake_next_head #(
      .X_BLOCKS (X_BLOCKS),
      .Y_BLOCKS (Y_BLOCKS)
   ) u_next_head (
      .head_x      (head.x),
      .head_y      (head.y),
      .heading     (heading),
      .direction   (step_dir),
      .next_x      (next_head.x),
      .next_y      (next_head.y),
      .new_heading (new_heading),
      .wall_hit    (wall_hit)
   );

   assign scan_done = (scan_idx == len);
   assign scan_hit  = !scan_done &&
                      (body[scan_idx[SNAKE_LENGTH_BIT-1:0]] == head);
   assign grow_ok   = step_grow && (len < LEN_MAX);
   assign rd_idx    = (body_count == LAST_IDX) ? '0 : body_count + 1'b1;

   assign busy      = (state == ST_UPDATE) || (state == ST_CHECK);
   assign game_over = (state == ST_OVER);

   assign snake_head_x = head.x;
   assign snake_head_y = head.y;
   assign snake_body_x = snake_body.x;
   assign snake_body_y = snake_body.y;
   // A full array of MAX entries wraps to zero on this narrower port.
   assign snake_length = len[SNAKE_LENGTH_BIT-1:0];

   // FSM state register
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_n;
   end

   // FSM next state; restart overrides everything
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:
            if (pending || move_tick) state_n = ST_UPDATE;
         ST_UPDATE:
            state_n = wall_hit ? ST_OVER : ST_CHECK;
         ST_CHECK:
            if (scan_hit)       state_n = ST_OVER;
            else if (scan_done) state_n = ST_IDLE;
         default:
            state_n = ST_OVER;
      endcase
      if (restart) state_n = ST_IDLE;
   end

   // Step capture, pending tick, head/body update and scan index
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         head      <= INIT_HEAD;
         heading   <= DIR_RIGHT;
         body      <= body_init();
         len       <= LEN_INIT;
         scan_idx  <= '0;
         step_dir  <= DIR_RIGHT;
         step_grow <= 1'b0;
         pending   <= 1'b0;
         pend_dir  <= DIR_RIGHT;
         pend_grow <= 1'b0;
      end else if (restart) begin
         head      <= INIT_HEAD;
         heading   <= DIR_RIGHT;
         body      <= body_init();
         len       <= LEN_INIT;
         scan_idx  <= '0;
         step_grow <= 1'b0;
         pending   <= 1'b0;
         pend_grow <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE:
               if (pending) begin
                  step_dir  <= pend_dir;
                  step_grow <= pend_grow;
                  pending   <= 1'b0;
               end else if (move_tick) begin
                  step_dir  <= dir_t'(direction);
                  step_grow <= grow;
               end
            ST_UPDATE: begin
               scan_idx <= '0;
               if (!wall_hit) begin
                  heading <= dir_t'(new_heading);
                  head    <= next_head;
                  body[0] <= head;
                  for (int i = 1; i < SNAKE_LENGTH_MAX; i++)
                     if (i < int'(len) || (grow_ok && i == int'(len)))
                        body[i] <= body[i-1];
                  if (grow_ok) len <= len + 1'b1;
               end
            end
            ST_CHECK:
               scan_idx <= scan_idx + 1'b1;
            default:
               pending <= 1'b0;
         endcase
         if (busy && move_tick && !pending) begin
            pending   <= 1'b1;
            pend_dir  <= dir_t'(direction);
            pend_grow <= grow;
         end
      end
   end

   // Body stream: index and entry advance together every cycle
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         body_count <= '0;
         snake_body <= INIT_BODY0;
      end else begin
         body_count <= rd_idx;
         snake_body <= ({1'b0, rd_idx} < len) ? body[rd_idx] : OFF_COORD;
      end
   end

endmodule

// File: tb/tb_snake_body_streamer.sv
// Scenario bench for snake_body_streamer with a queued scoreboard.
// A behavioural snake model predicts each step's outcome.
module tb_snake_body_streamer;

   logic       clock_25  = 1'b0;
   logic       reset     = 1'b1;
   logic       move_tick = 1'b0;
   logic [1:0] direction = 2'b01;
   logic       grow      = 1'b0;
   logic       restart   = 1'b0;
   logic [6:0] snake_head_x;
   logic [6:0] snake_head_y;
   logic [3:0] body_count;
   logic [6:0] snake_body_x;
   logic [6:0] snake_body_y;
   logic [3:0] snake_length;
   logic       game_over;
   logic       busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int hx;
      int hy;
      int len;
      int over;
      int bcyc;
   } exp_t;

   exp_t sbq[$];

   int mhx, mhy, mhd, mlen;
   bit mover;
   int mbx[16];
   int mby[16];

   snake_body_streamer #(
      .SNAKE_LENGTH_BIT (4),
      .SNAKE_LENGTH_MAX (16),
      .X_BLOCKS         (124),
      .Y_BLOCKS         (81)
   ) dut (
      .clock_25     (clock_25),
      .reset        (reset),
      .move_tick    (move_tick),
      .direction    (direction),
      .grow         (grow),
      .restart      (restart),
      .snake_head_x (snake_head_x),
      .snake_head_y (snake_head_y),
      .body_count   (body_count),
      .snake_body_x (snake_body_x),
      .snake_body_y (snake_body_y),
      .snake_length (snake_length),
      .game_over    (game_over),
      .busy         (busy)
   );

   always #20 clock_25 = ~clock_25;

   task automatic model_init();
      mhx = 62; mhy = 40; mhd = 1; mlen = 2; mover = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mbx[i] = 127; mby[i] = 127;
      end
      mbx[0] = 61; mby[0] = 40;
      mbx[1] = 60; mby[1] = 40;
   endtask

   // Predict one step and push its expected outcome
   task automatic model_step(input int d, input bit g);
      exp_t e;
      int nd, nx, ny;
      bit ge, hit;
      e.bcyc = 0;
      if (!mover) begin
         nd = (d == (mhd ^ 2)) ? mhd : d;
         nx = mhx; ny = mhy;
         case (nd)
            0: ny = ny - 1;
            1: nx = nx + 1;
            2: ny = ny + 1;
            default: nx = nx - 1;
         endcase
         if (nx < 0 || nx > 123 || ny < 0 || ny > 80) begin
            mover = 1'b1;
            e.bcyc = 1;
         end else begin
            ge = g && (mlen < 16);
            for (int i = 15; i >= 1; i--)
               if (i < mlen || (ge && i == mlen)) begin
                  mbx[i] = mbx[i-1]; mby[i] = mby[i-1];
               end
            mbx[0] = mhx; mby[0] = mhy;
            mhx = nx; mhy = ny; mhd = nd;
            if (ge) mlen = mlen + 1;
            e.bcyc = mlen + 2;
            hit = 1'b0;
            for (int k = 0; k < 16; k++)
               if (!hit && k < mlen && mbx[k] == mhx && mby[k] == mhy) begin
                  hit = 1'b1;
                  mover = 1'b1;
                  e.bcyc = k + 2;
               end
         end
      end
      e.hx = mhx; e.hy = mhy; e.len = mlen % 16; e.over = int'(mover);
      sbq.push_back(e);
   endtask

   task automatic pulse_tick(input int d, input bit g);
      @(negedge clock_25);
      move_tick = 1'b1; direction = 2'(d); grow = g;
      @(negedge clock_25);
      move_tick = 1'b0; grow = 1'b0;
   endtask

   task automatic pulse_restart();
      @(negedge clock_25);
      restart = 1'b1;
      @(negedge clock_25);
      restart = 1'b0;
      model_init();
   endtask

   // Count busy-high cycles of the next step (bounded)
   task automatic wait_busy(output int cnt);
      int guard;
      cnt = 0; guard = 0;
      while (!busy && guard < 3) begin
         @(negedge clock_25); guard++;
      end
      while (busy && cnt < 64) begin
         cnt++; @(negedge clock_25);
      end
   endtask

   task automatic test_stream(input string tag);
      int c0, idx, ex, ey;
      c0 = int'(body_count);
      for (int k = 0; k < 17; k++) begin
         idx = (c0 + k) % 16;
         ex = (idx < mlen) ? mbx[idx] : 127;
         ey = (idx < mlen) ? mby[idx] : 127;
         checks++;
         if (body_count !== 4'(idx) || snake_body_x !== 7'(ex) ||
             snake_body_y !== 7'(ey)) begin
            errors++;
            $display("FAIL stream_%s: got idx=%0d (%0d,%0d) want idx=%0d (%0d,%0d)",
                     tag, body_count, snake_body_x, snake_body_y, idx, ex, ey);
         end
         @(negedge clock_25);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #5 reset = 1'b0;
      model_init();
      @(negedge clock_25);
      @(negedge clock_25);
      checks++;
      if (snake_head_x !== 7'd62 || snake_head_y !== 7'd40) begin
         errors++;
         $display("FAIL reset_head: got (%0d,%0d) want (62,40)",
                  snake_head_x, snake_head_y);
      end
      checks++;
      if (body_count !== 4'd0 || snake_body_x !== 7'd61 ||
          snake_body_y !== 7'd40) begin
         errors++;
         $display("FAIL reset_stream: got idx=%0d (%0d,%0d) want idx=0 (61,40)",
                  body_count, snake_body_x, snake_body_y);
      end
      checks++;
      if (snake_length !== 4'd2 || game_over !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got len=%0d over=%0b busy=%0b want 2 0 0",
                  snake_length, game_over, busy);
      end
      reset = 1'b1;
      test_stream("reset");
   endtask

   task automatic test_move();
      exp_t e;
      int c;
      pulse_restart();
      model_step(1, 1'b0);
      pulse_tick(1, 1'b0);
      wait_busy(c);
      e = sbq.pop_front();
      checks++;
      if (snake_head_x !== 7'(e.hx) || snake_head_y !== 7'(e.hy) ||
          snake_length !== 4'(e.len) || game_over !== 1'(e.over) ||
          c != e.bcyc) begin
         errors++;
         $display("FAIL move: got (%0d,%0d) len=%0d over=%0b busy=%0d want (%0d,%0d) len=%0d over=%0d busy=%0d",
                  snake_head_x, snake_head_y, snake_length, game_over, c,
                  e.hx, e.hy, e.len, e.over, e.bcyc);
      end
      test_stream("move");
   endtask

   task automatic test_reverse();
      exp_t e;
      int c;
      pulse_restart();
      model_step(3, 1'b0);
      pulse_tick(3, 1'b0);
      wait_busy(c);
      e = sbq.pop_front();
      checks++;
      if (snake_head_x !== 7'(e.hx) || snake_head_y !== 7'(e.hy) ||
          game_over !== 1'(e.over) || c != e.bcyc) begin
         errors++;
         $display("FAIL reverse: got (%0d,%0d) over=%0b busy=%0d want (%0d,%0d) over=%0d busy=%0d",
                  snake_head_x, snake_head_y, game_over, c,
                  e.hx, e.hy, e.over, e.bcyc);
      end
   endtask

   task automatic test_grow();
      exp_t e;
      int c;
      pulse_restart();
      for (int n = 0; n < 16; n++) begin
         model_step(1, 1'b1);
         pulse_tick(1, 1'b1);
         wait_busy(c);
         e = sbq.pop_front();
         checks++;
         if (snake_head_x !== 7'(e.hx) || snake_length !== 4'(e.len) ||
             game_over !== 1'(e.over) || c != e.bcyc) begin
            errors++;
            $display("FAIL grow_%0d: got x=%0d len=%0d over=%0b busy=%0d want x=%0d len=%0d over=%0d busy=%0d",
                     n, snake_head_x, snake_length, game_over, c,
                     e.hx, e.len, e.over, e.bcyc);
         end
         if (n == 0) test_stream("grow1");
      end
      test_stream("grow_full");
   endtask

   task automatic test_wall();
      exp_t e;
      int c;
      pulse_restart();
      while (mhx < 124 && !mover) begin
         model_step(1, 1'b0);
         pulse_tick(1, 1'b0);
         wait_busy(c);
         e = sbq.pop_front();
         checks++;
         if (snake_head_x !== 7'(e.hx) || snake_head_y !== 7'(e.hy) ||
             game_over !== 1'(e.over) || c != e.bcyc) begin
            errors++;
            $display("FAIL wall_walk: got (%0d,%0d) over=%0b busy=%0d want (%0d,%0d) over=%0d busy=%0d",
                     snake_head_x, snake_head_y, game_over, c,
                     e.hx, e.hy, e.over, e.bcyc);
         end
      end
      model_step(0, 1'b0);
      pulse_tick(0, 1'b0);
      wait_busy(c);
      e = sbq.pop_front();
      checks++;
      if (snake_head_x !== 7'(e.hx) || snake_head_y !== 7'(e.hy) ||
          game_over !== 1'(e.over) || c != e.bcyc) begin
         errors++;
         $display("FAIL wall_frozen: got (%0d,%0d) over=%0b busy=%0d want (%0d,%0d) over=%0d busy=%0d",
                  snake_head_x, snake_head_y, game_over, c,
                  e.hx, e.hy, e.over, e.bcyc);
      end
      test_stream("over");
      pulse_restart();
      checks++;
      if (snake_head_x !== 7'd62 || snake_head_y !== 7'd40 ||
          snake_length !== 4'd2 || game_over !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wall_restart: got (%0d,%0d) len=%0d over=%0b busy=%0b want (62,40) len=2 over=0 busy=0",
                  snake_head_x, snake_head_y, snake_length, game_over, busy);
      end
      test_stream("restart");
   endtask

   task automatic test_collision();
      exp_t e;
      int c;
      int dseq[6] = '{1, 1, 1, 0, 3, 2};
      bit gseq[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      pulse_restart();
      for (int n = 0; n < 6; n++) begin
         model_step(dseq[n], gseq[n]);
         pulse_tick(dseq[n], gseq[n]);
         wait_busy(c);
         e = sbq.pop_front();
         checks++;
         if (snake_head_x !== 7'(e.hx) || snake_head_y !== 7'(e.hy) ||
             snake_length !== 4'(e.len) || game_over !== 1'(e.over) ||
             c != e.bcyc) begin
            errors++;
            $display("FAIL collide_%0d: got (%0d,%0d) len=%0d over=%0b busy=%0d want (%0d,%0d) len=%0d over=%0d busy=%0d",
                     n, snake_head_x, snake_head_y, snake_length, game_over, c,
                     e.hx, e.hy, e.len, e.over, e.bcyc);
         end
      end
      test_stream("collide");
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int c, n;
      pulse_restart();
      model_step(1, 1'b0);
      model_step(2, 1'b0);
      @(negedge clock_25);
      move_tick = 1'b1; direction = 2'b01;
      @(negedge clock_25);
      move_tick = 1'b0;
      @(negedge clock_25);
      move_tick = 1'b1; direction = 2'b10;
      @(negedge clock_25);
      direction = 2'b11;
      @(negedge clock_25);
      move_tick = 1'b0;
      n = 0;
      while (busy && n < 64) begin
         @(negedge clock_25); n++;
      end
      e = sbq.pop_front();
      checks++;
      if (snake_head_x !== 7'(e.hx) || snake_head_y !== 7'(e.hy) || n >= 64) begin
         errors++;
         $display("FAIL b2b_first: got (%0d,%0d) want (%0d,%0d)",
                  snake_head_x, snake_head_y, e.hx, e.hy);
      end
      wait_busy(c);
      e = sbq.pop_front();
      checks++;
      if (snake_head_x !== 7'(e.hx) || snake_head_y !== 7'(e.hy) ||
          c != e.bcyc) begin
         errors++;
         $display("FAIL b2b_pending: got (%0d,%0d) busy=%0d want (%0d,%0d) busy=%0d",
                  snake_head_x, snake_head_y, c, e.hx, e.hy, e.bcyc);
      end
      c = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock_25);
         if (busy) c++;
      end
      checks++;
      if (c != 0 || snake_head_x !== 7'(mhx) || snake_head_y !== 7'(mhy)) begin
         errors++;
         $display("FAIL b2b_drop: got busy=%0d (%0d,%0d) want busy=0 (%0d,%0d)",
                  c, snake_head_x, snake_head_y, mhx, mhy);
      end
   endtask

   task automatic test_reset_abort();
      pulse_restart();
      pulse_tick(1, 1'b1);
      @(negedge clock_25);
      reset = 1'b0;
      @(negedge clock_25);
      reset = 1'b1;
      model_init();
      checks++;
      if (snake_head_x !== 7'd62 || snake_head_y !== 7'd40 ||
          snake_length !== 4'd2 || busy !== 1'b0 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL abort: got (%0d,%0d) len=%0d busy=%0b over=%0b want (62,40) len=2 busy=0 over=0",
                  snake_head_x, snake_head_y, snake_length, busy, game_over);
      end
      test_stream("abort");
   endtask

   initial begin
      test_reset();
      test_move();
      test_reverse();
      test_grow();
      test_wall();
      test_collision();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
